// File: rtl/branch_history_table_pkg.sv
// Shared definitions for the branch direction predictor: 2-bit counter states
// and default table geometry.
package branch_history_table_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_INDEX_WIDTH = 4;
  localparam int unsigned DEF_TAG_WIDTH   = 8;
  localparam int unsigned DEF_STAT_WIDTH  = 16;

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch lookup, EX-stage training and statistics signals of the branch history table.
interface branch_history_table_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAT_WIDTH = 16
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] pc;
  logic                  taken;
  logic                  hit;
  logic                  update_en;
  logic [DATA_WIDTH-1:0] update_pc;
  logic                  update_taken;
  logic [STAT_WIDTH-1:0] mispredict_count;

  modport master (
    output flush, pc, update_en, update_pc, update_taken,
    input  taken, hit, mispredict_count
  );

  modport slave (
    input  flush, pc, update_en, update_pc, update_taken,
    output taken, hit, mispredict_count
  );
endinterface

// File: rtl/branch_history_table_sat_counter.sv
// 2-bit saturating counter next-state function used on the training path.
module sat_counter_2bit
  import branch_history_table_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_dir,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_dir) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped tagged table of 2-bit counters predicting branch direction at fetch,
// trained by resolved conditional branches from EX.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int unsigned STAT_WIDTH  = DEF_STAT_WIDTH
)(
  input logic                    clk,
  input logic                    rst,
  branch_history_table_if.slave  bus
);

  localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_LO  = INDEX_WIDTH + 2;
  localparam int unsigned TAG_HI  = INDEX_WIDTH + TAG_WIDTH + 1;

  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_WIDTH-1:0]  r_tag [ENTRIES];
  logic [1:0]            r_ctr [ENTRIES];
  logic [STAT_WIDTH-1:0] r_mispred_cnt;

  logic [INDEX_WIDTH-1:0] w_lk_idx;
  logic [TAG_WIDTH-1:0]   w_lk_tag;
  logic                   w_lk_hit;
  logic [INDEX_WIDTH-1:0] w_upd_idx;
  logic [TAG_WIDTH-1:0]   w_upd_tag;
  logic                   w_upd_hit;
  logic [1:0]             w_upd_ctr_old;
  logic [1:0]             w_upd_ctr_next;
  logic                   w_old_pred;
  logic                   w_mispredict;
  logic                   w_unused;

  assign w_lk_idx  = bus.pc[INDEX_WIDTH+1:2];
  assign w_lk_tag  = bus.pc[TAG_HI:TAG_LO];
  assign w_upd_idx = bus.update_pc[INDEX_WIDTH+1:2];
  assign w_upd_tag = bus.update_pc[TAG_HI:TAG_LO];

  // Byte offset and PC bits above the tag take no part in the lookup.
  assign w_unused = ^{bus.pc[DATA_WIDTH-1:TAG_HI+1], bus.pc[1:0],
                      bus.update_pc[DATA_WIDTH-1:TAG_HI+1], bus.update_pc[1:0]};

  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign bus.hit   = w_lk_hit;
  assign bus.taken = w_lk_hit && r_ctr[w_lk_idx][1];
  assign bus.mispredict_count = r_mispred_cnt;

  assign w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_ctr_old = r_ctr[w_upd_idx];
  assign w_old_pred    = w_upd_hit && w_upd_ctr_old[1];
  assign w_mispredict  = bus.update_en && (w_old_pred != bus.update_taken);

  sat_counter_2bit u_sat_counter (
    .i_ctr (w_upd_ctr_old),
    .i_dir (bus.update_taken),
    .o_ctr (w_upd_ctr_next)
  );

  // Flush only clears valid bits and takes priority over training.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_tag   <= '{default: '0};
      r_ctr   <= '{default: CTR_WNT};
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (bus.update_en) begin
      r_valid[w_upd_idx] <= 1'b1;
      r_tag[w_upd_idx]   <= w_upd_tag;
      if (w_upd_hit)
        r_ctr[w_upd_idx] <= w_upd_ctr_next;
      else
        r_ctr[w_upd_idx] <= bus.update_taken ? CTR_WT : CTR_WNT;
    end
  end

  // The statistic is still counted on a flushed update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_mispred_cnt <= '0;
    else if (w_mispredict && (r_mispred_cnt != '1))
      r_mispred_cnt <= r_mispred_cnt + STAT_WIDTH'(1);
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: driver queues expectations, monitor checks at negedge.
module tb_branch_history_table;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] PC_A = 32'h0040_0010; // index 4, tag 0x00
  localparam logic [31:0] PC_B = 32'h0040_0410; // index 4, tag 0x10
  localparam logic [31:0] PC_C = 32'h0040_0020; // index 8, tag 0x00

  branch_history_table_if #(.DATA_WIDTH(32), .STAT_WIDTH(16)) bus ();

  branch_history_table #(
    .DATA_WIDTH (32),
    .INDEX_WIDTH(4),
    .TAG_WIDTH  (8),
    .STAT_WIDTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic f, input logic [31:0] p,
                     input logic ue, input logic [31:0] up, input logic ut,
                     input logic chk, input logic eh, input logic et,
                     input logic [15:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.flush        = f;
    bus.pc           = p;
    bus.update_en    = ue;
    bus.update_pc    = up;
    bus.update_taken = ut;
    if (chk) begin
      e.name = nm; e.hit = eh; e.taken = et; e.cnt = ec;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.hit !== e.hit || bus.taken !== e.taken || bus.mispredict_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b cnt=%h, want hit=%b taken=%b cnt=%h",
                 e.name, bus.hit, bus.taken, bus.mispredict_count, e.hit, e.taken, e.cnt);
      end
    end
  end

  initial begin
    bus.flush = 1'b0; bus.pc = PC_A; bus.update_en = 1'b0;
    bus.update_pc = '0; bus.update_taken = 1'b0;

    //   rst  fl  pc    ue  upc   ut  chk hit tk  cnt
    cyc(1'b1, 0, PC_A, 0, PC_A, 0, 1, 0, 0, 16'd0, "reset");
    cyc(1'b0, 0, PC_A, 1, PC_A, 1, 1, 0, 0, 16'd0, "same_cycle_untrained");
    cyc(1'b0, 0, PC_A, 1, PC_A, 1, 1, 1, 1, 16'd1, "first_alloc_wt");
    cyc(1'b0, 0, PC_A, 1, PC_A, 1, 1, 1, 1, 16'd1, "ctr_st");
    cyc(1'b0, 0, PC_A, 1, PC_A, 0, 1, 1, 1, 16'd1, "ctr_st_hold");
    cyc(1'b0, 0, PC_A, 1, PC_A, 0, 1, 1, 1, 16'd2, "after_nt1_wt");
    cyc(1'b0, 0, PC_A, 0, PC_A, 0, 1, 1, 0, 16'd3, "after_nt2_wnt");
    cyc(1'b0, 0, PC_A, 1, PC_A, 1, 1, 1, 0, 16'd3, "retrain_from_wnt");
    cyc(1'b0, 0, PC_A, 1, PC_B, 0, 1, 1, 1, 16'd4, "alias_update");
    cyc(1'b0, 0, PC_A, 0, PC_A, 0, 1, 0, 0, 16'd4, "alias_evicts_a");
    cyc(1'b0, 0, PC_B, 0, PC_A, 0, 1, 1, 0, 16'd4, "alias_b_wnt");
    cyc(1'b0, 1, PC_C, 1, PC_C, 1, 1, 0, 0, 16'd4, "flush_with_update");
    cyc(1'b0, 0, PC_C, 0, PC_C, 0, 1, 0, 0, 16'd5, "flush_discards_update");
    cyc(1'b0, 0, PC_B, 0, PC_C, 0, 1, 0, 0, 16'd5, "flush_clears_b");

    // Flushed taken updates always miss, so every cycle is a misprediction.
    for (int i = 0; i < 65529; i++)
      cyc(1'b0, 1, PC_A, 1, PC_C, 1, 0, 0, 0, 16'd0, "");
    cyc(1'b0, 1, PC_A, 1, PC_C, 1, 1, 0, 0, 16'hFFFE, "sat_below_max");
    cyc(1'b0, 1, PC_A, 1, PC_C, 1, 1, 0, 0, 16'hFFFF, "sat_at_max");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1, PC_A, 1, PC_C, 1, 0, 0, 0, 16'd0, "");
    cyc(1'b0, 0, PC_A, 1, PC_A, 1, 1, 0, 0, 16'hFFFF, "sat_holds");
    cyc(1'b0, 0, PC_A, 0, PC_A, 0, 1, 1, 1, 16'hFFFF, "trained_before_rst");
    // Async reset asserted between edges while an update is pending.
    cyc(1'b1, 0, PC_A, 1, PC_A, 1, 1, 0, 0, 16'd0, "async_rst_midcycle");
    cyc(1'b0, 0, PC_A, 0, PC_A, 0, 1, 0, 0, 16'd0, "rst_drops_update");
    cyc(1'b0, 0, PC_A, 1, PC_A, 0, 1, 0, 0, 16'd0, "alloc_nt_no_mispred");
    cyc(1'b0, 0, PC_A, 0, PC_A, 0, 1, 1, 0, 16'd0, "alloc_nt_wnt");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
